// File: rtl/logic_unit_pkg.sv
// Shared logic-unit types, opcodes and the bitwise operation; combinational, no latency.
// No handshake here, so no backpressure.
package logic_unit_pkg;

  localparam int MAX_W = 64;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_LSB = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } lu_state_t;

  // Operands arrive zero-extended to MAX_W; callers truncate back to their width.
  function automatic logic [MAX_W-1:0] logic_op(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input logic [1:0]       op);
    logic [MAX_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = {{(MAX_W-1){1'b0}}, a[0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between requesters, the shared logic unit and its consumer.
// valid/ready on both sides; the arbiter is the slave.
interface logic_unit_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*2-1:0]     req_op;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [ID_W-1:0]        resp_id;
  logic [WIDTH-1:0]       resp_data;
  logic                   resp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_zero
  );
endinterface

// File: rtl/logic_unit_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr wins; purely combinational.
// en low forces no grant, which is how callers apply backpressure.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  int idx;

  // Scan from the farthest offset down so the nearest request to ptr is written last.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    idx    = 0;
    if (en) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        idx = int'(ptr) + k;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (req[idx]) begin
          gnt      = '0;
          gnt[idx] = 1'b1;
          gnt_id   = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of one bitwise logic unit; result registered, 1-cycle latency.
// Response held until resp_ready; no request is granted while a held response is stalled.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);

  lu_state_t         state_q;
  lu_state_t         state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              can_accept;
  logic              accept;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic [1:0]        op_sel;
  logic [WIDTH-1:0]  result;
  logic [ID_W-1:0]   ptr_next;

  // rst_n gates the grant so nothing is offered while reset is held.
  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .en     (can_accept & rst_n),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign bus.req_ready = gnt;
  assign accept        = |(bus.req_valid & gnt);

  always_comb begin
    a_sel  = bus.req_a[int'(gnt_id)*WIDTH +: WIDTH];
    b_sel  = bus.req_b[int'(gnt_id)*WIDTH +: WIDTH];
    op_sel = bus.req_op[int'(gnt_id)*2 +: 2];
    result = WIDTH'(logic_op(MAX_W'(a_sel), MAX_W'(b_sel), op_sel));
    ptr_next = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: if (accept) state_d = HOLD;
            else if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.resp_valid = (state_q == HOLD);
    can_accept     = (state_q == IDLE) || bus.resp_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      bus.resp_id   <= '0;
      bus.resp_data <= '0;
      bus.resp_zero <= 1'b0;
    end else if (accept) begin
      ptr_q         <= ptr_next;
      bus.resp_id   <= gnt_id;
      bus.resp_data <= result;
      bus.resp_zero <= (result == '0);
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: scoreboard of accepted ops plus directed boundary checks.
module tb_logic_unit_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    logic        zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(2)) bus ();

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return {31'd0, a[0]};
    endcase
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_op[i*2 +: 2] = op;
    bus.req_a[i*W +: W]  = a;
    bus.req_b[i*W +: W]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire the current response before recording this cycle's accept.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_resp_id", 64'(bus.resp_id), 64'(e.id));
          check("sb_resp_data", 64'(bus.resp_data), 64'(e.data));
          check("sb_resp_zero", 64'(bus.resp_zero), 64'(e.zero));
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_t e;
          e.id   = 2'(i);
          e.data = model(bus.req_a[i*W +: W], bus.req_b[i*W +: W], bus.req_op[i*2 +: 2]);
          e.zero = (e.data == 32'd0);
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] lit [3];

  initial begin
    lit[0] = 32'h00F0_00F0;
    lit[1] = 32'hFFF0_FFF0;
    lit[2] = 32'hFF00_FF00;

    rst_n          = 1'b0;
    bus.req_valid  = '1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'h0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
    check("rst_resp_data", 64'(bus.resp_data), 64'h0);
    check("rst_resp_id", 64'(bus.resp_id), 64'h0);
    check("rst_resp_zero", 64'(bus.resp_zero), 64'h0);

    // Release: requester 0 offered first, then everyone withdraws before the edge.
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_first_grant", 64'(bus.req_ready), 64'h1);
    bus.req_valid = '0;

    // LSB op from requester 2, zero and non-zero results.
    tick();
    set_req(2, 2'b11, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("lsb_grant", 64'(bus.req_ready), 64'h4);
    tick();
    set_req(2, 2'b11, 32'h0000_0003, 32'h0);
    @(negedge clk);
    check("lsb0_id", 64'(bus.resp_id), 64'd2);
    check("lsb0_data", 64'(bus.resp_data), 64'h0);
    check("lsb0_zero", 64'(bus.resp_zero), 64'd1);
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("lsb1_data", 64'(bus.resp_data), 64'h1);
    check("lsb1_zero", 64'(bus.resp_zero), 64'd0);

    // Requester 3 moves ptr to 0 ahead of the round-robin sweep.
    tick();
    set_req(3, 2'b10, 32'h1234_5678, 32'h1234_5678);
    bus.req_valid = 4'b1000;
    tick();
    for (int i = 0; i < N; i++) set_req(i, 2'(i), 32'h1111_1111 * (i + 1), 32'h0F0F_0F0F);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rr_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
      if (k == 0) check("rr_prev_id", 64'(bus.resp_id), 64'd3);
      else        check("rr_resp_id", 64'(bus.resp_id), 64'((k - 1) % 4));
      tick();
    end

    // Stall a held response (requester 0: AND) with requester 1 waiting.
    bus.req_valid  = 4'b0010;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_req_ready", 64'(bus.req_ready), 64'h0);
      check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      check("bp_resp_id", 64'(bus.resp_id), 64'd0);
      check("bp_resp_data", 64'(bus.resp_data), 64'h0101_0101);
      tick();
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("bp_next_id", 64'(bus.resp_id), 64'd1);
    check("bp_next_valid", 64'(bus.resp_valid), 64'd1);

    // Back-to-back AND/OR/XOR from requester 0.
    tick();
    set_req(0, 2'd0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k < 2) set_req(0, 2'(k + 1), 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      else       bus.req_valid = 4'b0000;
      @(negedge clk);
      check("op_data", 64'(bus.resp_data), 64'(lit[k]));
      check("op_valid", 64'(bus.resp_valid), 64'd1);
    end

    // Reset while a response is held.
    tick();
    set_req(2, 2'd2, 32'h0000_0005, 32'h0);
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b0;
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("mid_hold_valid", 64'(bus.resp_valid), 64'd1);
    check("mid_hold_data", 64'(bus.resp_data), 64'h5);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("arst_resp_data", 64'(bus.resp_data), 64'h0);
    check("arst_resp_id", 64'(bus.resp_id), 64'h0);
    tick();
    rst_n          = 1'b1;
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("arst_first_grant", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("arst_first_id", 64'(bus.resp_id), 64'd0);
    repeat (3) tick();
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one 32-bit bitwise logic unit (AND / OR / XOR / LSB-mask) among N_REQ requesters using round-robin arbitration and valid/ready handshakes. It accepts one operation per cycle from the granted requester and registers the result, tagged with the requester ID and a zero flag. The response is held until the consumer takes it. The block sits between the branch/flag logic clients and the shared logic datapath, so LSB-mask and zero-detect operations are serialized through one unit.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width
- ID_W, $clog2(N_REQ), requester ID width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high (one-hot or zero)
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B, same packing
- req_op  in  N_REQ*2  opcode, requester i at [i*2 +: 2]
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_id  out  ID_W  index of the requester that issued this result
- resp_data  out  WIDTH  registered result
- resp_zero  out  1  1 when resp_data == 0

## Operation
- Opcodes: 00 AND (a&b), 01 OR (a|b), 10 XOR (a^b), 11 LSB (a & 1, upper WIDTH-1 bits zero; b ignored).
- States: IDLE (no response held) and HOLD (resp_valid=1).
- can_accept = (state==IDLE) | (state==HOLD & resp_ready).
- Grant: when can_accept, pick the first i with req_valid[i], scanning ptr, ptr+1, … mod N_REQ. Drive req_ready[i]=1 for that i only. No valid request means req_ready is all zero.
- Accept (req_valid[g] & req_ready[g]):
  - Compute the result from the granted operands.
  - Next edge: resp_data, resp_zero and resp_id load, resp_valid=1, state=HOLD, ptr=(g+1) mod N_REQ.
- HOLD with resp_ready=1 and no accept: next edge state=IDLE, resp_valid=0. resp_data, resp_id and resp_zero keep their last values.
- HOLD with resp_ready=0: all resp_* outputs hold stable and req_ready is all zero.
- Simultaneous resp handshake and new accept: state stays HOLD and the new result loads. This gives full throughput of one op per cycle.
- ptr advances only on accept, never on idle cycles.
- Requesters may drop req_valid before being granted. The block holds no per-requester state, so the request is simply lost.

## Timing
- Reset values: state=IDLE, ptr=0, resp_valid=0, resp_data=0, resp_id=0, resp_zero=0. req_ready is all zero while rst_n=0.
- Latency: the result appears on resp_* at the edge after the accept (1 cycle).
- req_ready is combinational from req_valid, state, ptr and resp_ready. There is no combinational path from req_a, req_b or req_op to any output.
- Throughput: 1 op/cycle while resp_ready=1.
- Fairness: a continuously asserted request is granted within N_REQ accepts.
- Reset asserted mid-HOLD: outputs return to reset values immediately (asynchronous) and the pending response is discarded.

## Structure
- Package logic_unit_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_XOR, OP_LSB;
  - the state enum (IDLE, HOLD);
  - the function logic_op(a, b, op) returning the WIDTH-bit result.
- Sub-module rr_pick (combinational): inputs req[N_REQ], ptr[ID_W], en; outputs gnt one-hot and gnt_id. It is reused by other shared-resource arbiters.
- Top level: rr_pick, operand mux, logic_op, response register, and the ptr/state flops.

## Test plan
- Reset: hold rst_n=0, drive all req_valid=1 -> req_ready=0, resp_valid=0, resp_data=0. Release reset -> requester 0 is granted first.
- Single op: req 2 issues op=11, a=32'hFFFF_FFFE -> next cycle resp_id=2, resp_data=0, resp_zero=1. Then a=32'h0000_0003 -> resp_data=1, resp_zero=0.
- Round-robin: all 4 requesters valid, resp_ready=1 -> grants in order 0,1,2,3,0. Each accepts on consecutive cycles and resp_id follows one cycle later.
- Backpressure: resp_ready=0 for 5 cycles with req 1 pending -> resp_* stable and req_ready=0. Raise resp_ready -> req 1 is accepted the same cycle and its response appears the next cycle.
- Op coverage: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0 -> AND=32'h00F0_00F0, OR=32'hFFF0_FFF0, XOR=32'hFF00_FF00.
- Reset mid-HOLD: assert rst_n=0 while resp_valid=1 -> resp_valid=0 without waiting for a clock edge. After release, ptr=0 and requester 0 has priority.
